tlb_lookup_unit: RTL and testbench
==================================

// Module: tlb_lookup_unit
// PURPOSE
//  Responder side of the MMU<->TLB translation handshake: a fully associative, 4 KB-page MIPS32 joint TLB.
//  Accepts lookups (tlb_en/tlb_vaddr/tlb_refs) from the MMU, returns paddr, cacheability and refill/invalid/modified
//  flags with tlb_rdy. The entry write port is driven by CP0 on TLBWI/TLBWR. Sits beside the MMU in the core.
// PARAMETERS
//  NENTRY  16  number of TLB entries (power of 2, 2..32)
//  IDXW    4   index width, = log2(NENTRY)
// PORTS
//  clk          in   1      core clock
//  rst          in   1      synchronous active-high reset
//  tlb_en       in   1      lookup request, held high until tlb_rdy is seen
//  tlb_vaddr    in   32     virtual address to translate
//  tlb_refs     in   1      1 = store access (dirty check applies)
//  asid         in   8      current EntryHi.ASID
//  tlb_rdy      out  1      result valid this cycle
//  tlb_paddr    out  32     {PFN[19:0], vaddr[11:0]}
//  tlb_cat      out  1      1 = cacheable (C == 3'b011)
//  tlb_tlbr     out  1      miss (refill exception)
//  tlb_tlbi     out  1      hit, V=0 (invalid exception)
//  tlb_tlbm     out  1      store hit, V=1, D=0 (modified exception)
//  wr_en        in   1      write entry wr_index this cycle
//  wr_index     in   IDXW   entry to write
//  wr_entryhi   in   32     VPN2=[31:13], ASID=[7:0]
//  wr_entrylo0  in   32     even page: PFN=[25:6] C=[5:3] D=[2] V=[1] G=[0]
//  wr_entrylo1  in   32     odd page, same format
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; every entry zeroed (V0=V1=G=0, so no entry can hit).
//  Entry write: single cycle, visible to any compare from the next cycle. Stored G = lo0.G & lo1.G.
//  FSM IDLE -> CMP -> RESP:
//   IDLE: if tlb_en, latch vaddr, refs and asid -> CMP.
//   CMP: compare every entry against the latched request in parallel; register the result -> RESP.
//    Hit requires VPN2 == vaddr[31:13] and (G | ASID == latched asid).
//   RESP: tlb_rdy=1 and outputs driven from the registered result.
//    Stay in RESP while tlb_en is high, inputs equal the latched request, and wr_en=0.
//    If tlb_en is high and any of vaddr/refs/asid differ, or wr_en=1: relatch -> CMP (tlb_rdy=0 next cycle).
//    If tlb_en is low: -> IDLE (wr_en also leads to IDLE).
//  Latency: tlb_rdy rises 2 cycles after tlb_en is first sampled high.
//   Back-to-back new request: 2 cycles (RESP->CMP->RESP).
//  Result rules: multiple hits resolve to the lowest index. vaddr[12] selects lo1 (1) or lo0 (0).
//   Miss: tlbr=1. Hit with V=0: tlbi=1. refs & V & !D: tlbm=1. Exactly one flag, or none.
//   Any flag set: tlb_paddr=0 and tlb_cat=0.
//  Outside RESP: tlb_rdy, tlb_paddr, tlb_cat and all flags are 0.
//  wr_en in IDLE together with a new tlb_en: the CMP uses the post-write array.
//  Reset mid-operation: returns to IDLE on the next edge; the pending request is dropped; the MMU re-requests.
// TESTING
//  T1 after reset, tlb_en=1, vaddr=0x00402ABC -> tlb_rdy=1 at cycle 2 with tlbr=1, paddr=0.
//  T2 write idx3 hi=0x00402005, lo0=0x00048D1E, lo1=0x00048D5C; load 0x00402ABC with asid=0x05
//     -> paddr=0x01234ABC, cat=1, no flags.
//  T3 same entry with lo1 V=0, load 0x00403ABC -> tlbi=1. Store to 0x00402ABC after rewriting lo0 with D=0 -> tlbm=1.
//  T4 asid=0x06 with G=0 -> tlbr. Rewrite with both G=1, asid=0x06 -> hit, paddr=0x01234ABC.
//  T5 same VPN2 in idx1 (PFN 0x00111) and idx3 -> paddr=0x00111ABC.
//     wr_en in RESP -> tlb_rdy=0 for 1 cycle, then the new result.
//  T6 rst asserted in CMP -> next cycle IDLE, all outputs 0, all entries invalid (next lookup gives tlbr).

Source files
------------

// File: rtl/tlb_lookup_unit.sv
// Fully associative MIPS32 joint TLB (4 KB pages) answering MMU lookups over an en/rdy handshake.
// Each entry maps an even/odd page pair; CP0 writes entries through a single-cycle write port.
module tlb_lookup_unit #(
  parameter int NENTRY = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tlb_en,
  input  logic [31:0]     tlb_vaddr,
  input  logic            tlb_refs,
  input  logic [7:0]      asid,
  output logic            tlb_rdy,
  output logic [31:0]     tlb_paddr,
  output logic            tlb_cat,
  output logic            tlb_tlbr,
  output logic            tlb_tlbi,
  output logic            tlb_tlbm,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_index,
  input  logic [31:0]     wr_entryhi,
  input  logic [31:0]     wr_entrylo0,
  input  logic [31:0]     wr_entrylo1
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_e;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    page_t       even;
    page_t       odd;
  } entry_t;

  typedef struct packed {
    logic [31:0] vaddr;
    logic        refs;
    logic [7:0]  asid;
  } req_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        cat;
    logic        tlbr;
    logic        tlbi;
    logic        tlbm;
  } res_t;

  state_e state_q, state_d;
  req_t   req_q, req_d;
  res_t   res_q, res_d;
  entry_t ent_q [NENTRY];
  entry_t ent_d [NENTRY];

  entry_t            wr_entry;
  logic              latch_req;
  logic              req_changed;
  logic [NENTRY-1:0] match;
  logic              hit;
  logic [IDXW-1:0]   hit_idx;
  page_t             sel;
  res_t              cmp_res;

  // Reserved EntryHi/EntryLo bits carry no state in this TLB.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_entryhi[12:8], wr_entrylo0[31:26], wr_entrylo1[31:26]};

  always_comb begin
    wr_entry.vpn2      = wr_entryhi[31:13];
    wr_entry.asid      = wr_entryhi[7:0];
    wr_entry.g         = wr_entrylo0[0] & wr_entrylo1[0];
    wr_entry.even.pfn  = wr_entrylo0[25:6];
    wr_entry.even.c    = wr_entrylo0[5:3];
    wr_entry.even.d    = wr_entrylo0[2];
    wr_entry.even.v    = wr_entrylo0[1];
    wr_entry.odd.pfn   = wr_entrylo1[25:6];
    wr_entry.odd.c     = wr_entrylo1[5:3];
    wr_entry.odd.d     = wr_entrylo1[2];
    wr_entry.odd.v     = wr_entrylo1[1];
  end

  // NOTE: every always_comb output gets a full default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    ent_d = ent_q;
    if (wr_en) ent_d[wr_index] = wr_entry;
  end

  always_comb begin
    for (int i = 0; i < NENTRY; i++) begin
      match[i] = (ent_q[i].vpn2 == req_q.vaddr[31:13]) &&
                 (ent_q[i].g || (ent_q[i].asid == req_q.asid));
    end
  end

  // Scan downward so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NENTRY - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    sel     = req_q.vaddr[12] ? ent_q[hit_idx].odd : ent_q[hit_idx].even;
    cmp_res = '0;
    if (!hit) begin
      cmp_res.tlbr = 1'b1;
    end else if (!sel.v) begin
      cmp_res.tlbi = 1'b1;
    end else if (req_q.refs && !sel.d) begin
      cmp_res.tlbm = 1'b1;
    end else begin
      cmp_res.paddr = {sel.pfn, req_q.vaddr[11:0]};
      cmp_res.cat   = (sel.c == 3'b011);
    end
  end

  assign req_changed = ({tlb_vaddr, tlb_refs, asid} != req_q);

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tlb_en) begin
          latch_req = 1'b1;
          state_d   = S_CMP;
        end
      end
      S_CMP: state_d = S_RESP;
      S_RESP: begin
        if (!tlb_en) begin
          state_d = S_IDLE;
        end else if (wr_en || req_changed) begin
          latch_req = 1'b1;
          state_d   = S_CMP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d = latch_req ? {tlb_vaddr, tlb_refs, asid} : req_q;
    res_d = (state_q == S_CMP) ? cmp_res : res_q;
  end

  // Output logic: the registered result is only exposed while responding.
  always_comb begin
    tlb_rdy   = (state_q == S_RESP);
    tlb_paddr = tlb_rdy ? res_q.paddr : '0;
    tlb_cat   = tlb_rdy & res_q.cat;
    tlb_tlbr  = tlb_rdy & res_q.tlbr;
    tlb_tlbi  = tlb_rdy & res_q.tlbi;
    tlb_tlbm  = tlb_rdy & res_q.tlbm;
  end

  // NOTE: the entry array is reset like any other register: a cleared V/G
  // guarantees no stale translation can hit after reset, which a RAM cannot give.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      res_q   <= '0;
      ent_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      res_q   <= res_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Self-checking bench for tlb_lookup_unit: directed scenarios pinned to literal values,
// then randomized traffic compared every cycle against a transaction-level TLB model.
module tb_tlb_lookup_unit;

  localparam int NENTRY = 16;
  localparam int IDXW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            tlb_en;
  logic [31:0]     tlb_vaddr;
  logic            tlb_refs;
  logic [7:0]      asid;
  logic            tlb_rdy;
  logic [31:0]     tlb_paddr;
  logic            tlb_cat, tlb_tlbr, tlb_tlbi, tlb_tlbm;
  logic            wr_en;
  logic [IDXW-1:0] wr_index;
  logic [31:0]     wr_entryhi, wr_entrylo0, wr_entrylo1;

  tlb_lookup_unit #(.NENTRY(NENTRY), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .tlb_en(tlb_en), .tlb_vaddr(tlb_vaddr), .tlb_refs(tlb_refs), .asid(asid),
    .tlb_rdy(tlb_rdy), .tlb_paddr(tlb_paddr), .tlb_cat(tlb_cat),
    .tlb_tlbr(tlb_tlbr), .tlb_tlbi(tlb_tlbi), .tlb_tlbm(tlb_tlbm),
    .wr_en(wr_en), .wr_index(wr_index),
    .wr_entryhi(wr_entryhi), .wr_entrylo0(wr_entrylo0), .wr_entrylo1(wr_entrylo1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [31:0] paddr;
    logic        cat;
    logic        tlbr;
    logic        tlbi;
    logic        tlbm;
  } out_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi  [NENTRY];
  logic [31:0] m_lo0 [NENTRY];
  logic [31:0] m_lo1 [NENTRY];
  bit          m_live = 1'b0;
  bit          m_busy = 1'b0;
  int          m_age  = 0;   // 1 = being compared, 2 = answer on the bus
  logic [31:0] m_va;
  logic        m_refs;
  logic [7:0]  m_asid;
  out_t        m_res;

  function automatic out_t translate(input logic [31:0] va, input logic refs, input logic [7:0] as);
    out_t        r;
    logic [31:0] lo;
    r = '0;
    for (int i = 0; i < NENTRY; i++) begin
      if ((m_hi[i] >> 13) == (va >> 13) &&
          ((m_lo0[i][0] & m_lo1[i][0]) || m_hi[i][7:0] == as)) begin
        lo = va[12] ? m_lo1[i] : m_lo0[i];
        if (!lo[1])                r.tlbi = 1'b1;
        else if (refs && !lo[2])   r.tlbm = 1'b1;
        else begin
          r.paddr = {lo[25:6], va[11:0]};
          r.cat   = (lo[5:3] == 3'b011);
        end
        return r;
      end
    end
    r.tlbr = 1'b1;
    return r;
  endfunction

  function automatic out_t exp_out();
    out_t r;
    r = '0;
    if (m_busy && m_age == 2) begin
      r     = m_res;
      r.rdy = 1'b1;
    end
    return r;
  endfunction

  function automatic out_t dut_out();
    return {tlb_rdy, tlb_paddr, tlb_cat, tlb_tlbr, tlb_tlbi, tlb_tlbm};
  endfunction

  always @(posedge clk) begin
    bit accept;
    accept = 1'b0;
    if (rst) begin
      m_live = 1'b1;
      m_busy = 1'b0;
      m_age  = 0;
      for (int i = 0; i < NENTRY; i++) begin
        m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0;
      end
    end else if (m_live) begin
      if (!m_busy) accept = tlb_en;
      else if (m_age == 1) begin
        m_age = 2;
        m_res = translate(m_va, m_refs, m_asid);  // array as it was before this edge's write
      end
      else if (!tlb_en) m_busy = 1'b0;
      else if (wr_en || tlb_vaddr != m_va || tlb_refs != m_refs || asid != m_asid) accept = 1'b1;
      if (accept) begin
        m_busy = 1'b1; m_age = 1;
        m_va = tlb_vaddr; m_refs = tlb_refs; m_asid = asid;
      end
      if (wr_en) begin
        m_hi[wr_index]  = wr_entryhi;
        m_lo0[wr_index] = wr_entrylo0;
        m_lo1[wr_index] = wr_entrylo1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) check("cycle", dut_out(), exp_out());
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int idx, input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    wr_en = 1'b1; wr_index = IDXW'(idx);
    wr_entryhi = hi; wr_entrylo0 = lo0; wr_entrylo1 = lo1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] va, input logic refs, input logic [7:0] as,
                        output out_t d, output out_t m, output int lat);
    tlb_en = 1'b1; tlb_vaddr = va; tlb_refs = refs; asid = as;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (tlb_rdy) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) check({tag, "_rdy_timeout"}, tlb_rdy, 1);
    d = dut_out();
    m = exp_out();
  endtask

  task automatic release_req();
    tlb_en = 1'b0;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    out_t d, m;
    int   lat;

    rst = 1'b1; tlb_en = 1'b0; tlb_vaddr = '0; tlb_refs = 1'b0; asid = '0;
    wr_en = 1'b0; wr_index = '0; wr_entryhi = '0; wr_entrylo0 = '0; wr_entrylo1 = '0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_outputs", dut_out(), 0);

    // T1: empty TLB misses, answer two cycles after request
    lookup("t1", 32'h00402ABC, 1'b0, 8'h00, d, m, lat);
    check("t1_latency", lat, 2);
    check("t1_tlbr", d.tlbr, 1);
    check("t1_paddr", d.paddr, 0);
    check("t1_model_tlbr", m.tlbr, 1);
    release_req();

    // T2: plain hit, cacheable
    wr(3, 32'h00402005, 32'h00048D1E, 32'h00048D5C);
    lookup("t2", 32'h00402ABC, 1'b0, 8'h05, d, m, lat);
    check("t2_paddr", d.paddr, 32'h01234ABC);
    check("t2_cat", d.cat, 1);
    check("t2_flags", {d.tlbr, d.tlbi, d.tlbm}, 0);
    check("t2_model_paddr", m.paddr, 32'h01234ABC);
    release_req();

    // T3: odd page invalid; store to clean even page
    lookup("t3i", 32'h00403ABC, 1'b0, 8'h05, d, m, lat);
    check("t3_tlbi", {d.tlbr, d.tlbi, d.tlbm}, 3'b010);
    check("t3_tlbi_paddr", d.paddr, 0);
    release_req();
    wr(3, 32'h00402005, 32'h00048D1A, 32'h00048D5C);
    lookup("t3m", 32'h00402ABC, 1'b1, 8'h05, d, m, lat);
    check("t3_tlbm", {d.tlbr, d.tlbi, d.tlbm}, 3'b001);
    check("t3_tlbm_cat", d.cat, 0);
    check("t3_model_tlbm", {m.tlbr, m.tlbi, m.tlbm}, 3'b001);
    release_req();
    lookup("t3l", 32'h00402ABC, 1'b0, 8'h05, d, m, lat);
    check("t3_load_clean", d.paddr, 32'h01234ABC);
    release_req();

    // T4: ASID mismatch, then global entry
    lookup("t4r", 32'h00402ABC, 1'b0, 8'h06, d, m, lat);
    check("t4_asid_miss", d.tlbr, 1);
    release_req();
    wr(3, 32'h00402005, 32'h00048D1F, 32'h00048D5D);
    lookup("t4g", 32'h00402ABC, 1'b0, 8'h06, d, m, lat);
    check("t4_global_paddr", d.paddr, 32'h01234ABC);
    check("t4_global_cat", d.cat, 1);

    // T5: write during RESP re-runs the compare; lowest index wins
    wr_en = 1'b1; wr_index = 4'd1;
    wr_entryhi = 32'h00402006; wr_entrylo0 = 32'h0000445E; wr_entrylo1 = 32'h0000445C;
    step();
    wr_en = 1'b0;
    check("t5_rdy_drop", tlb_rdy, 0);
    step();
    check("t5_rdy_back", tlb_rdy, 1);
    check("t5_low_index", tlb_paddr, 32'h00111ABC);
    check("t5_model_low_index", exp_out().paddr, 32'h00111ABC);
    step();
    check("t5_hold", {tlb_rdy, tlb_paddr}, {1'b1, 32'h00111ABC});
    release_req();

    // T6: reset while comparing clears state and entries
    tlb_en = 1'b1; tlb_vaddr = 32'h00402ABC; tlb_refs = 1'b0; asid = 8'h06;
    step();
    rst = 1'b1; tlb_en = 1'b0;
    step();
    check("t6_reset_outputs", dut_out(), 0);
    rst = 1'b0;
    lookup("t6", 32'h00402ABC, 1'b0, 8'h06, d, m, lat);
    check("t6_entries_cleared", d.tlbr, 1);
    check("t6_latency", lat, 2);
    release_req();

    // Randomized traffic: small VPN2/ASID space so hits, aliases and flags all occur
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (tlb_en) tlb_en = ($urandom_range(0, 9) != 0);
      else        tlb_en = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) begin
        tlb_vaddr = ($urandom_range(0, 3) << 13) | ($urandom_range(0, 1) << 12) | $urandom_range(0, 4095);
        tlb_refs  = $urandom_range(0, 1);
        asid      = 8'($urandom_range(1, 2));
      end
      wr_en = ($urandom_range(0, 7) == 0);
      wr_index = IDXW'($urandom_range(0, NENTRY - 1));
      wr_entryhi  = ($urandom_range(0, 3) << 13) | ($urandom_range(0, 31) << 8) | $urandom_range(1, 2);
      wr_entrylo0 = $urandom;
      wr_entrylo1 = $urandom;
      step();
    end

    rst = 1'b0; tlb_en = 1'b0; wr_en = 1'b0;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
